// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, the 128-bit state type and the
// MixColumns FSM encoding.
package aes_pkg;

  typedef logic [0:127] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  // Row-0 coefficients, one nibble each, most significant nibble multiplies a0.
  localparam logic [15:0] MC_FWD_COEF = 16'h2311;
  localparam logic [15:0] MC_INV_COEF = 16'hebd9;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by any constant below 16, built from repeated xtime.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[0]}} & b) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns of one 32-bit column (row 0 in bits [31:24]).
// With MIXCOL_INV_EN defined an inv input selects InvMixColumns.
module mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
`ifdef MIXCOL_INV_EN
  input  logic        inv,
`endif
  output logic [31:0] col_out
);

  logic [15:0] coef;

  always_comb begin
    coef = MC_FWD_COEF;
`ifdef MIXCOL_INV_EN
    if (inv) coef = MC_INV_COEF;
`endif
  end

  // Each output row uses the row-0 coefficients rotated right by the row index.
  always_comb begin
    logic [7:0] acc;
    col_out = '0;
    for (int i = 0; i < 4; i++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++) begin
        acc = acc ^ gf_mul_const(col_in[31-8*j -: 8], coef[12-4*((j-i+4)%4) +: 4]);
      end
      col_out[31-8*i -: 8] = acc;
    end
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: one column per cycle, five cycles per block.
// Defining MIXCOL_INV_EN adds the inv port and InvMixColumns.
module mix_columns_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
`ifdef MIXCOL_INV_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holds valid and its data stable until that edge.

  mc_state_e  state_q, state_d;
  logic [1:0] col_q, col_d;
  aes_state_t blk_q, blk_d;
  aes_state_t res_q, res_d;
  logic [31:0] col_in, col_out;
  logic        accept;
`ifdef MIXCOL_INV_EN
  logic        inv_q, inv_d;
`endif

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign out_state = res_q;
  assign col_in    = blk_q[{col_q, 5'b0} +: 32];

  mix_single_column u_col (
    .col_in  (col_in),
`ifdef MIXCOL_INV_EN
    .inv     (inv_q),
`endif
    .col_out (col_out)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    blk_d   = blk_q;
    res_d   = res_q;
`ifdef MIXCOL_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          blk_d   = in_state;
`ifdef MIXCOL_INV_EN
          inv_d   = inv;
`endif
          col_d   = 2'd0;
          state_d = BUSY;
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        res_d[{col_q, 5'b0} +: 32] = col_out;
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      blk_q   <= '0;
      res_q   <= '0;
`ifdef MIXCOL_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
`ifdef MIXCOL_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: directed steps, reference model, expected queue.
// Inverse-mode steps are included when MIXCOL_INV_EN is defined.
module tb_mix_columns_iter;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_state;
  logic         inv;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  mix_columns_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
`ifdef MIXCOL_INV_EN
    .inv       (inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // reference model: shift-and-add multiply, explicit matrix
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? (({x[6:0], 1'b0}) ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [0:127] model_mix(input logic [0:127] s, input logic inv_m);
    logic [7:0] m [4];
    logic [7:0] a [4];
    logic [7:0] o;
    logic [0:127] r;
    if (inv_m) begin
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int q = 0; q < 4; q++) a[q] = s[c*32 + q*8 +: 8];
      for (int i = 0; i < 4; i++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++) o = o ^ gmul(a[j], m[(j - i + 4) % 4]);
        r[c*32 + i*8 +: 8] = o;
      end
    end
    return r;
  endfunction

  function automatic logic [0:127] rand_state();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // scoreboard: compare every output handshake against the queue head
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_out_valid", W'(out_valid), W'(0));
      else check("out_state", out_state, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [0:127] s, input logic iv, input bit push, input logic [0:127] expv);
    int waited;
    in_state = s;
    inv      = iv;
    in_valid = 1'b1;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (in_ready !== 1'b1) check("accept_timeout", W'(in_ready), W'(1));
    if (push) exp_q.push_back(expv);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", W'(exp_q.size()), W'(0));
  endtask

  logic [0:127] va, vb, vexp;
  int gap;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0; inv = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_out_state", out_state, W'(0));
    check("reset_in_ready", W'(in_ready), W'(1));

    // known column in all four positions; out_valid exactly four edges after accept
    out_ready = 1'b1;
    send(128'hdb135345_db135345_db135345_db135345, 1'b0, 1'b1,
         128'h8e4da1bc_8e4da1bc_8e4da1bc_8e4da1bc);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("latency_edge_%0d", i), W'(out_valid), W'(i == 4));
    end
    tick();
    check("idle_after_take", W'(in_ready), W'(1));
    check("valid_drop_after_take", W'(out_valid), W'(0));

    // mixed columns including identity-like and carry-heavy ones
    send(128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5, 1'b0, 1'b1,
         128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6);
    drain();

    // backpressure in DONE: everything holds, new input is refused
    out_ready = 1'b0;
    va = rand_state();
    vexp = model_mix(va, 1'b0);
    send(va, 1'b0, 1'b1, vexp);
    gap = 0;
    while (out_valid !== 1'b1 && gap < 20) begin
      tick();
      gap++;
    end
    in_state = rand_state();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("hold_out_state", out_state, vexp);
      check("hold_out_valid", W'(out_valid), W'(1));
      check("hold_in_ready", W'(in_ready), W'(0));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // in_valid held: second block accepted five edges after the first
    va = rand_state();
    vb = rand_state();
    in_state = va;
    in_valid = 1'b1;
    exp_q.push_back(model_mix(va, 1'b0));
    tick();
    in_state = vb;
    gap = 0;
    while (in_ready !== 1'b1 && gap < 20) begin
      tick();
      gap++;
    end
    check("b2b_accept_gap", W'(gap + 1), W'(5));
    exp_q.push_back(model_mix(vb, 1'b0));
    tick();
    in_valid = 1'b0;
    drain();

    // reset while column 2 is being transformed: block is dropped
    send(rand_state(), 1'b0, 1'b0, '0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_out_state", out_state, W'(0));
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_in_ready", W'(in_ready), W'(1));
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort_no_valid", W'(out_valid), W'(0));
    end

    // random forward blocks with irregular downstream readiness
    for (int i = 0; i < 4; i++) begin
      va = rand_state();
      out_ready = 1'(($urandom_range(0, 1)));
      send(va, 1'b0, 1'b1, model_mix(va, 1'b0));
      repeat ($urandom_range(4, 8)) tick();
      out_ready = 1'b1;
      drain();
    end

`ifdef MIXCOL_INV_EN
    send(128'h8e4da1bc_8e4da1bc_8e4da1bc_8e4da1bc, 1'b1, 1'b1,
         128'hdb135345_db135345_db135345_db135345);
    drain();
    for (int i = 0; i < 4; i++) begin
      va = rand_state();
      vb = model_mix(va, 1'b0);
      send(va, 1'b0, 1'b1, vb);
      send(vb, 1'b1, 1'b1, va);
      drain();
    end
`endif

    drain();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
